// File: rtl/signal_period_meter_pkg.sv
// Shared definitions for the period meter: FSM encodings and default sizing,
// also picked up by the clock-divider bench.
package signal_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 27;
    localparam int DEF_TIMEOUT     = 120_000_000;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/signal_period_meter_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input followed by a history flop
// that yields single-cycle rise/fall pulses in the clk_100MHz domain.
module edge_sync
    import signal_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise_det,
    output logic fall_det
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_s;
        end
    end

    assign rise_det = sync_s & ~prev_q;
    assign fall_det = ~sync_s & prev_q;

endmodule

// File: rtl/signal_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// clk_100MHz cycles, with a sticky timeout for a stalled input.
module signal_period_meter
    import signal_period_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0] period_d, high_time_d;
    logic             meas_valid_d, timeout_d;
    logic             rise_det, fall_det;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .rise_det  (rise_det),
        .fall_det  (fall_det)
    );

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_tmp_q   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_tmp_q   <= hi_tmp_d;
            period     <= period_d;
            high_time  <= high_time_d;
            meas_valid <= meas_valid_d;
            timeout    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_tmp_d     = hi_tmp_q;
        period_d     = period;
        high_time_d  = high_time;
        meas_valid_d = 1'b0;
        timeout_d    = timeout;

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise_det) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_MEASURE;
                    end else if (cnt_q == TMO) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    // A rising edge on the same cycle as the limit still yields a result.
                    if (rise_det) begin
                        period_d     = cnt_q;
                        high_time_d  = hi_tmp_q;
                        meas_valid_d = 1'b1;
                        timeout_d    = 1'b0;
                        cnt_d        = CNT_W'(1);
                    end else if (cnt_q == TMO) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (fall_det) begin
                            hi_tmp_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_signal_period_meter.sv
// Directed bench for signal_period_meter: square waves of several shapes,
// timeout, enable drop and asynchronous reset.
module tb_signal_period_meter;

    localparam int CNT_W = 27;
    localparam int TMO   = 50;

    logic             clk_100MHz;
    logic             reset_n;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    int vectors;
    int miscompares;

    signal_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(2)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".period"},     32'(period),    0);
        check({tag, ".high_time"},  32'(high_time), 0);
        check({tag, ".meas_valid"}, 32'(meas_valid), 0);
        check({tag, ".timeout"},    32'(timeout),   0);
        check({tag, ".busy"},       32'(busy),      0);
    endtask

    // Drop enable with the input parked low, then re-enable and let the
    // synchroniser settle so the next wave starts from ARM with a clean history.
    task automatic rearm();
        sig_in = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        repeat (4) tick();
    endtask

    // Square wave starting with a rising edge at iteration 0. The rise is seen
    // by the FSM two edges later, so the k-th rise (k>=1) strobes at k*p+2.
    task automatic wave(input int hi, input int lo, input int n, input logic init_to);
        int  p;
        logic exp_v;
        p = hi + lo;
        for (int j = 0; j < n; j++) begin
            sig_in = ((j % p) < hi);
            tick();
            exp_v = (j >= p + 2) && (((j - 2) % p) == 0);
            check("meas_valid", 32'(meas_valid), 32'(exp_v));
            if (exp_v) begin
                check("period",    32'(period),    32'(p));
                check("high_time", 32'(high_time), 32'(hi));
            end
            check("busy",    32'(busy),    1);
            check("timeout", 32'(timeout), 32'(init_to && (j < p + 2)));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        enable      = 1'b0;
        sig_in      = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        #3 reset_n = 1'b1;

        // 50% square, period 10
        rearm();
        wave(5, 5, 45, 1'b0);

        // 3 high / 7 low
        rearm();
        wave(3, 7, 45, 1'b0);

        // fastest input: toggle every cycle
        rearm();
        wave(1, 1, 20, 1'b0);

        // period equal to the timeout limit: edge wins over timeout
        rearm();
        wave(25, 25, 110, 1'b0);

        // enable dropped mid-period, input keeps running
        rearm();
        wave(5, 5, 27, 1'b0);
        enable = 1'b0;
        for (int j = 27; j < 40; j++) begin
            sig_in = ((j % 10) < 5);
            tick();
            check("dis.busy",       32'(busy),       0);
            check("dis.meas_valid", 32'(meas_valid), 0);
            check("dis.period",     32'(period),     10);
            check("dis.high_time",  32'(high_time),  5);
        end
        rearm();
        check("reen.period",    32'(period),    10);
        check("reen.high_time", 32'(high_time), 5);
        wave(5, 5, 15, 1'b0);

        // single rising edge then a stuck-low input
        rearm();
        for (int j = 0; j < 58; j++) begin
            sig_in = (j < 3);
            tick();
            check("tmo.meas_valid", 32'(meas_valid), 0);
            check("tmo.busy",       32'(busy),       1);
            check("tmo.timeout",    32'(timeout),    32'(j >= 52));
        end
        wave(5, 5, 25, 1'b1);

        // asynchronous reset between edges while measuring
        rearm();
        wave(5, 5, 17, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        sig_in = 1'b0;
        tick();
        tick();
        check_all_zero("rst_hold");
        #3 reset_n = 1'b1;
        tick();
        check("post_rst.period", 32'(period), 0);
        check("post_rst.busy",   32'(busy),   1);
        rearm();
        wave(5, 5, 35, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signal_period_meter.md
Name: signal_period_meter

Overview:
Measures the period and high time of a slow, asynchronous square wave (e.g. the 1 Hz demo clock or an external pulse) in clk_100MHz cycles. It is the receiving end of the clock-divider path: the divider produces a known slow signal, and this block checks it. The block synchronises the input, detects edges and runs a small FSM. Each full period produces one result with a one-cycle valid strobe. A timeout flags a stalled input.

Parameters:
CNT_W, 27, width of the period/high-time counters and outputs (covers >100,000,000 cycles).
TIMEOUT, 120_000_000, cycles without a rising edge before timeout is raised; must be < 2**CNT_W.
SYNC_STAGES, 2, synchroniser flop count on sig_in (>=2).

Ports:
clk_100MHz  input  1  system clock, 100 MHz.
reset_n  input  1  reset.
enable  input  1  measurement enable; low forces IDLE.
sig_in  input  1  asynchronous signal under measurement.
period  output  CNT_W  cycles between the last two rising edges.
high_time  output  CNT_W  cycles sig_in was high within that period.
meas_valid  output  1  one-cycle strobe; period/high_time updated this cycle.
timeout  output  1  sticky stall flag.
busy  output  1  high in ARM or MEASURE.

Behaviour:
- Clocking and reset: one clock, clk_100MHz. Reset_n is asynchronous, active-low.
- Reset values: period=0, high_time=0, meas_valid=0, timeout=0, busy=0, counter=0, all synchroniser flops=0, state=IDLE.
- Synchroniser: SYNC_STAGES flops, then one history flop.
  - rise_det = sync & ~prev; fall_det = ~sync & prev.
  - Edge-detect latency is SYNC_STAGES+1 cycles from the sig_in transition.
- FSM states:
  - IDLE: busy=0, counter held at 0. Goes to ARM when enable=1.
  - ARM: waits for the first rise_det. The counter increments from 0. On rise_det, set cnt=1 and go to MEASURE (no result). If cnt reaches TIMEOUT, set timeout=1, cnt=0 and stay in ARM.
  - MEASURE:
    - cnt increments every cycle.
    - On fall_det: hi_tmp <= cnt.
    - On rise_det: period <= cnt, high_time <= hi_tmp, meas_valid=1 for that cycle, timeout <= 0, cnt <= 1, stay in MEASURE (back-to-back results).
    - If cnt reaches TIMEOUT: timeout=1, go to ARM with cnt=0. The partial measurement is discarded.
- Definitions: if rise_det occurs at cycles t and t+N with fall_det at t+H, then period=N and high_time=H.
- Minimum measurable input: 2 cycles (period=2, high_time=1).
- Simultaneous events: rise_det and timeout in the same cycle — rise_det wins and a result is produced.
- enable low: state goes to IDLE on the next edge, cnt=0 and timeout=0. Any measurement in flight is dropped. period/high_time hold their last values. meas_valid is never asserted in IDLE.
- Outputs: period and high_time are registered and stable between strobes. timeout clears only on meas_valid or on enable=0.
- Counter: never wraps; bounded by TIMEOUT.
- Reset mid-operation: immediate return to reset values. The first result after release needs two rising edges.

Decomposition:
- Shared package/include: FSM state encodings (ST_IDLE, ST_ARM, ST_MEASURE) and the default CNT_W/TIMEOUT constants, also used by the clock-divider bench.
- One sub-module, edge_sync: SYNC_STAGES synchroniser plus rise/fall detect, with clk_100MHz/reset_n ports. Reusable by the button/debounce blocks.

Test Plan:
1. sig_in 50% square, toggling every 5 cycles, enable=1 -> first meas_valid at the 2nd synced rising edge; period=10, high_time=5; then meas_valid every 10 cycles; timeout=0.
2. sig_in high 3 / low 7 repeating -> period=10, high_time=3 on every strobe; busy=1 throughout.
3. sig_in toggling every cycle -> period=2, high_time=1, meas_valid every 2 cycles.
4. TIMEOUT=50, one rising edge then sig_in held low -> timeout=1 exactly 50 cycles after the edge is detected, state ARM, no meas_valid. Resume a period-10 input -> next strobe gives period=10 and timeout=0.
5. enable dropped mid-period, then re-raised -> busy falls the next cycle, no strobe, period/high_time keep their previous values (10/5). After re-enable, the first strobe needs two rising edges.
6. reset_n pulsed low asynchronously between clock edges mid-MEASURE -> all outputs 0 immediately. After release, results resume per scenario 1.
